ring_input_vc: RTL and testbench

Parametrised ring-router input port that generalises the two-VC, single-register input stage to NUM_VC virtual channels, each with a DEPTH-entry FIFO. Each arriving flit is steered into the VC given by `vc_sel`. The head of each VC is classified by its hop field: hop 0 requests the local PE output, non-zero requests the onward ring output. On the ring path the hop field is decremented. It sits between a ring link receiver and the per-direction output arbiters, one instance per ring input (cw/ccw).

---
 rtl/ring_input_vc.sv | 92 +++++++++
 tb/tb_ring_input_vc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ring_input_vc.sv
// Ring-router input port with NUM_VC virtual channels, each backed by a DEPTH-entry FIFO.
// Each VC head requests the PE output (hop==0) or the ring output (hop!=0, presented with hop decremented).
module ring_input_vc #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 4,
  parameter int HOP_LSB    = 48,
  parameter int HOP_WIDTH  = 8,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           si,
  input  logic [VC_W-1:0]                vc_sel,
  input  logic [DATA_WIDTH-1:0]          di,
  output logic [NUM_VC-1:0]              ri,
  output logic [NUM_VC-1:0]              req_ring,
  output logic [NUM_VC-1:0]              req_pe,
  input  logic [NUM_VC-1:0]              gnt_ring,
  input  logic [NUM_VC-1:0]              gnt_pe,
  output logic [NUM_VC*DATA_WIDTH-1:0]   data_ring,
  output logic [NUM_VC*DATA_WIDTH-1:0]   data_pe,
  output logic [NUM_VC*(PTR_W+1)-1:0]    occ,
  output logic                           ovf
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [NUM_VC-1:0] full_v;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        cnt;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_dec;
    logic [HOP_WIDTH-1:0]  hop;

    assign empty     = (cnt == '0);
    assign full_v[v] = (cnt == FULL_CNT);
    assign ri[v]     = !full_v[v];
    assign push      = si && (vc_sel == VC_W'(v)) && !full_v[v];

    // Head is forced to zero when empty so both data outputs and the hop compare are clean.
    assign head        = empty ? '0 : mem[rd_ptr];
    assign hop         = head[HOP_LSB +: HOP_WIDTH];
    assign req_pe[v]   = !empty && (hop == '0);
    assign req_ring[v] = !empty && (hop != '0);
    assign pop         = (req_ring[v] && gnt_ring[v]) || (req_pe[v] && gnt_pe[v]);

    always_comb begin
      head_dec = head;
      head_dec[HOP_LSB +: HOP_WIDTH] = hop - HOP_WIDTH'(1);
      if (empty) head_dec = '0;
    end

    assign data_pe[v*DATA_WIDTH +: DATA_WIDTH]   = head;
    assign data_ring[v*DATA_WIDTH +: DATA_WIDTH] = head_dec;
    assign occ[v*(PTR_W+1) +: (PTR_W+1)]         = cnt;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= di;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + (PTR_W+1)'(1);
          2'b01:   cnt <= cnt - (PTR_W+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    ovf <= 1'b0;
    else if (si && full_v[vc_sel]) ovf <= 1'b1;
  end

endmodule

// File: tb/tb_ring_input_vc.sv
// Directed self-checking bench for ring_input_vc (NUM_VC=2, DEPTH=4, hop at [55:48]).
module tb_ring_input_vc;
  logic         clk = 1'b0;
  logic         rst;
  logic         si;
  logic [0:0]   vc_sel;
  logic [63:0]  di;
  logic [1:0]   ri, req_ring, req_pe, gnt_ring, gnt_pe;
  logic [127:0] data_ring, data_pe;
  logic [5:0]   occ;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  ring_input_vc #(.DATA_WIDTH(64), .NUM_VC(2), .DEPTH(4), .HOP_LSB(48), .HOP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .si(si), .vc_sel(vc_sel), .di(di), .ri(ri),
    .req_ring(req_ring), .req_pe(req_pe), .gnt_ring(gnt_ring), .gnt_pe(gnt_pe),
    .data_ring(data_ring), .data_pe(data_pe), .occ(occ), .ovf(ovf)
  );

  always #5 clk = ~clk;

  wire [63:0] dr0 = data_ring[63:0];
  wire [63:0] dr1 = data_ring[127:64];
  wire [63:0] dp0 = data_pe[63:0];
  wire [63:0] dp1 = data_pe[127:64];
  wire [2:0]  oc0 = occ[2:0];
  wire [2:0]  oc1 = occ[5:3];

  function automatic logic [63:0] mk(input logic [7:0] h, input logic [47:0] p);
    return {8'h5A, h, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [63:0] d);
    si = 1'b1; vc_sel = v; di = d;
    tick();
    si = 1'b0;
  endtask

  initial begin
    rst = 1'b0; si = 1'b0; vc_sel = '0; di = '0; gnt_ring = '0; gnt_pe = '0;
    #2;
    chk("rst_occ", occ, 6'd0);
    chk("rst_ri", ri, 2'b11);
    chk("rst_req", {req_ring, req_pe}, 4'b0);
    chk("rst_data", data_ring | data_pe, 64'd0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b1;

    // ring path on VC1
    push(1'b1, mk(8'h03, 48'h111));
    chk("r_req_ring", req_ring, 2'b10);
    chk("r_req_pe", req_pe, 2'b00);
    chk("r_data_ring1", dr1, mk(8'h02, 48'h111));
    chk("r_data_pe1", dp1, mk(8'h03, 48'h111));
    chk("r_occ1", oc1, 3'd1);
    gnt_ring = 2'b10; tick(); gnt_ring = '0;
    chk("r_pop_req", req_ring, 2'b00);
    chk("r_pop_occ1", oc1, 3'd0);
    chk("r_pop_data1", dr1, 64'd0);

    // PE path on VC0, mismatched grant, double grant
    push(1'b0, mk(8'h00, 48'h222));
    chk("p_req_pe", req_pe, 2'b01);
    chk("p_req_ring", req_ring, 2'b00);
    chk("p_data_pe0", dp0, mk(8'h00, 48'h222));
    gnt_ring = 2'b01; tick(); gnt_ring = '0;
    chk("p_wrong_gnt_occ0", oc0, 3'd1);
    chk("p_wrong_gnt_req", req_pe, 2'b01);
    push(1'b0, mk(8'h00, 48'h333));
    chk("p_occ0_2", oc0, 3'd2);
    gnt_ring = 2'b01; gnt_pe = 2'b01; tick(); gnt_ring = '0; gnt_pe = '0;
    chk("p_dual_gnt_occ0", oc0, 3'd1);
    chk("p_dual_gnt_head", dp0, mk(8'h00, 48'h333));
    gnt_pe = 2'b01; tick(); gnt_pe = '0;
    chk("p_empty_occ0", oc0, 3'd0);

    // overflow: five pushes into a 4-deep VC0
    for (int i = 1; i <= 5; i++) begin
      push(1'b0, mk(8'h01, 48'(i)));
      if (i == 4) begin
        chk("o_ri_full", ri, 2'b10);
        chk("o_ovf_before", ovf, 1'b0);
      end
    end
    chk("o_ovf_set", ovf, 1'b1);
    chk("o_occ0_full", oc0, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      gnt_ring = 2'b01;
      if (i == 1) chk("o_no_bypass_ri", ri, 2'b10);
      chk($sformatf("o_drain%0d", i), dr0, mk(8'h00, 48'(i)));
      tick();
    end
    gnt_ring = '0;
    chk("o_drained", oc0, 3'd0);
    chk("o_ovf_sticky", ovf, 1'b1);

    // VC0 fills and stalls while VC1 streams through with occ 1
    push(1'b1, mk(8'h00, 48'h500));
    for (int k = 0; k < 8; k++) begin
      si = 1'b1;
      if (k % 2 == 0) begin
        vc_sel = 1'b0; di = mk(8'h07, 48'(16'h600 + k)); gnt_pe = 2'b00;
      end else begin
        vc_sel = 1'b1; di = mk(8'h00, 48'(16'h500 + k)); gnt_pe = 2'b10;
      end
      tick();
      chk($sformatf("s_occ1_k%0d", k), oc1, 3'd1);
    end
    si = 1'b0; gnt_pe = '0;
    chk("s_occ0_full", oc0, 3'd4);
    chk("s_vc1_head", dp1, mk(8'h00, 48'h507));
    chk("s_vc0_head", dr0, mk(8'h06, 48'h600));
    gnt_pe = 2'b10; gnt_ring = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    gnt_pe = '0; gnt_ring = '0;
    chk("s_drained", occ, 6'd0);

    // pointer wrap on VC1 with simultaneous push/pop
    push(1'b1, mk(8'h05, 48'h1000));
    for (int i = 1; i <= 10; i++) begin
      si = 1'b1; vc_sel = 1'b1; di = mk(8'h05, 48'(32'h1000 + i)); gnt_ring = 2'b10;
      chk($sformatf("w_head%0d", i), dr1, mk(8'h04, 48'(32'h1000 + i - 1)));
      tick();
    end
    si = 1'b0;
    chk("w_last", dr1, mk(8'h04, 48'h100A));
    tick(); gnt_ring = '0;
    chk("w_empty", oc1, 3'd0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) push(1'b0, mk(8'h02, 48'(32'h700 + i)));
    chk("a_occ0_3", oc0, 3'd3);
    #2 rst = 1'b0;
    #1;
    chk("a_occ", occ, 6'd0);
    chk("a_req", {req_ring, req_pe}, 4'b0);
    chk("a_ri", ri, 2'b11);
    chk("a_data", data_ring | data_pe, 64'd0);
    chk("a_ovf", ovf, 1'b0);
    rst = 1'b1;
    push(1'b0, mk(8'h00, 48'h999));
    chk("a_post_head", dp0, mk(8'h00, 48'h999));
    chk("a_post_req", req_pe, 2'b01);
    chk("a_post_occ", oc0, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
